// File: rtl/mtrx_pkg.sv
// -----------------------------------------------------------------------------
// mtrx_pkg
// Shared constants and types for the matrix streaming blocks.
//   - Matrix-format constants: a flattened matrix is MTRX_ROWS x MTRX_COLS
//     signed elements of MTRX_ELEM_W bits each (4 x 4 x 21 = 336 bits).
//   - Frame defaults (matrices per frame, inter-matrix gap).
//   - Stream sequencer state encoding.
//   - Counter widths and a helper that turns a 0-based matrix slot into
//     the 1-based index shown on the output.
// -----------------------------------------------------------------------------
package mtrx_pkg;

  // Matrix format
  localparam int MTRX_ROWS   = 4;
  localparam int MTRX_COLS   = 4;
  localparam int MTRX_ELEM_W = 21;
  localparam int MTRX_W_DEF  = MTRX_ROWS * MTRX_COLS * MTRX_ELEM_W;

  // Frame defaults and legal ranges
  localparam int N_MTRX_DEF = 6;
  localparam int N_MTRX_MAX = 15;
  localparam int GAP_DEF    = 6;
  localparam int GAP_MAX    = 15;

  // Gap counter covers 0..GAP_MAX; the output index field is 4 bits so a
  // full 15-matrix frame fits with 0 reserved for "nothing presented".
  localparam int GAP_CNT_W = $clog2(GAP_MAX + 1);
  localparam int IDX_W     = 4;

  // Stream sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } mtrx_state_e;

  // 0-based slot -> 1-based output index
  function automatic logic [IDX_W-1:0] idx_of(input logic [IDX_W-1:0] k);
    return k + IDX_W'(1);
  endfunction

endpackage

// File: rtl/mtrx_snap_bank.sv
// -----------------------------------------------------------------------------
// mtrx_snap_bank
// Snapshot register bank for one frame of matrices plus the slot mux that
// selects the matrix being presented.
//
// Parameters
//   N_MTRX  matrices per frame
//   MTRX_W  width of one flattened matrix
// Ports
//   CLK      clock, rising edge
//   rst      asynchronous active-high reset, clears every slot
//   load     capture all of mtrx_in on this edge
//   mtrx_in  N_MTRX packed matrices, slot k at [(k+1)*MTRX_W-1 : k*MTRX_W]
//   sel      slot to present (0-based)
//   data     contents of slot sel
// -----------------------------------------------------------------------------
module mtrx_snap_bank #(
  parameter int  N_MTRX = 6,
  parameter int  MTRX_W = 336,
  localparam int SEL_W  = $clog2(N_MTRX)
) (
  input  logic                     CLK,
  input  logic                     rst,
  input  logic                     load,
  input  logic [N_MTRX*MTRX_W-1:0] mtrx_in,
  input  logic [SEL_W-1:0]         sel,
  output logic [MTRX_W-1:0]        data
);

  logic [MTRX_W-1:0] r_bank [N_MTRX];

  // Slots change only on load, so the frame in flight is unaffected by
  // whatever the producer does to mtrx_in meanwhile.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_MTRX; i++) begin
        r_bank[i] <= '0;
      end
    end else if (load) begin
      for (int i = 0; i < N_MTRX; i++) begin
        r_bank[i] <= mtrx_in[i*MTRX_W +: MTRX_W];
      end
    end
  end

  assign data = r_bank[sel];

endmodule

// File: rtl/mtrx_stream_seq.sv
// -----------------------------------------------------------------------------
// mtrx_stream_seq
// Streams a frame of N_MTRX matrices, captured atomically at frame start,
// over a valid/ready output with GAP idle cycles between matrices.
//
// Parameters
//   N_MTRX  matrices per frame (2..15)
//   MTRX_W  width of one flattened signed matrix
//   GAP     idle cycles between consecutive transfers (0..15)
// Ports
//   CLK          clock, rising edge
//   rst          asynchronous active-high reset
//   start        frame-start request (accepted only in IDLE)
//   abort        synchronous frame cancel, highest priority
//   cont         continuous mode, sampled in DONE
//   mtrx_in      N_MTRX packed matrices
//   out_ready    consumer accepts the presented matrix
//   out_valid    out_data/out_idx valid
//   out_data     presented matrix (zero when out_valid=0)
//   out_idx      1-based index of presented matrix (zero when out_valid=0)
//   busy         high in every state except IDLE
//   done         one-cycle pulse after the last transfer of a frame
//   overrun      sticky: start seen while busy; cleared by an accepted start
//   o_dbg_state  current FSM state (mtrx_state_e encoding)
//
// Handshake: a transfer happens on a rising edge where out_valid=1 and
// out_ready=1. While out_valid=1 and out_ready=0, out_data and out_idx hold
// steady. out_valid never depends combinationally on out_ready.
// -----------------------------------------------------------------------------
module mtrx_stream_seq
  import mtrx_pkg::*;
#(
  parameter int N_MTRX = N_MTRX_DEF,
  parameter int MTRX_W = MTRX_W_DEF,
  parameter int GAP    = GAP_DEF
) (
  input  logic                     CLK,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     cont,
  input  logic [N_MTRX*MTRX_W-1:0] mtrx_in,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic signed [MTRX_W-1:0] out_data,
  output logic [IDX_W-1:0]         out_idx,
  output logic                     busy,
  output logic                     done,
  output logic                     overrun,
  output logic [1:0]               o_dbg_state
);

  localparam int K_W = $clog2(N_MTRX);

  mtrx_state_e          r_state;
  logic [K_W-1:0]       r_k;
  logic [GAP_CNT_W-1:0] r_gap_cnt;
  logic                 r_out_valid;
  logic [IDX_W-1:0]     r_out_idx;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_overrun;

  logic                 w_load;
  logic [MTRX_W-1:0]    w_snap_data;
  logic                 w_last;
  logic                 w_gap_end;

  // Capture the frame whenever the FSM is about to (re)enter SEND at k=0:
  // an accepted start in IDLE or a continuous-mode restart from DONE.
  assign w_load = !abort &&
                  (((r_state == ST_IDLE) && start) ||
                   ((r_state == ST_DONE) && cont));

  assign w_last    = (r_k == K_W'(N_MTRX - 1));
  assign w_gap_end = (r_gap_cnt == GAP_CNT_W'(GAP - 1));

  mtrx_snap_bank #(
    .N_MTRX (N_MTRX),
    .MTRX_W (MTRX_W)
  ) u_snap_bank (
    .CLK     (CLK),
    .rst     (rst),
    .load    (w_load),
    .mtrx_in (mtrx_in),
    .sel     (r_k),
    .data    (w_snap_data)
  );

  // Sequencer. Output registers are updated together with the state so
  // out_valid/out_idx/busy/done always match the state they describe.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_k         <= '0;
      r_gap_cnt   <= '0;
      r_out_valid <= 1'b0;
      r_out_idx   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_done <= 1'b0;

      // A start outside IDLE is dropped but remembered.
      if (start && (r_state != ST_IDLE)) begin
        r_overrun <= 1'b1;
      end

      if (abort) begin
        r_state     <= ST_IDLE;
        r_k         <= '0;
        r_gap_cnt   <= '0;
        r_out_valid <= 1'b0;
        r_out_idx   <= '0;
        r_busy      <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (start) begin
              r_state     <= ST_SEND;
              r_k         <= '0;
              r_gap_cnt   <= '0;
              r_out_valid <= 1'b1;
              r_out_idx   <= idx_of('0);
              r_busy      <= 1'b1;
              r_overrun   <= 1'b0;
            end
          end

          ST_SEND: begin
            if (out_ready) begin
              if (w_last) begin
                r_state     <= ST_DONE;
                r_done      <= 1'b1;
                r_out_valid <= 1'b0;
                r_out_idx   <= '0;
              end else begin
                r_k <= r_k + K_W'(1);
                if (GAP == 0) begin
                  // Back-to-back: stay in SEND, present the next slot.
                  r_out_idx <= idx_of(IDX_W'(r_k) + IDX_W'(1));
                end else begin
                  r_state     <= ST_GAP;
                  r_gap_cnt   <= '0;
                  r_out_valid <= 1'b0;
                  r_out_idx   <= '0;
                end
              end
            end
          end

          ST_GAP: begin
            // Counts 0..GAP-1, one idle cycle per count, then resumes.
            if (w_gap_end) begin
              r_state     <= ST_SEND;
              r_gap_cnt   <= '0;
              r_out_valid <= 1'b1;
              r_out_idx   <= idx_of(IDX_W'(r_k));
            end else begin
              r_gap_cnt <= r_gap_cnt + GAP_CNT_W'(1);
            end
          end

          ST_DONE: begin
            if (cont) begin
              r_state     <= ST_SEND;
              r_k         <= '0;
              r_gap_cnt   <= '0;
              r_out_valid <= 1'b1;
              r_out_idx   <= idx_of('0);
              r_busy      <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end

          default: begin
            r_state     <= ST_IDLE;
            r_k         <= '0;
            r_gap_cnt   <= '0;
            r_out_valid <= 1'b0;
            r_out_idx   <= '0;
            r_busy      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign out_data    = r_out_valid ? w_snap_data : '0;
  assign out_idx     = r_out_idx;
  assign busy        = r_busy;
  assign done        = r_done;
  assign overrun     = r_overrun;
  assign o_dbg_state = r_state;

endmodule

// File: doc/mtrx_stream_seq.md
MTRX_STREAM_SEQ -- requirements
Module: mtrx_stream_seq

Interface
REQ-001 SHALL have parameter N_MTRX, default 6, giving the number of matrices sent per frame (range 2..15).
REQ-002 SHALL have parameter MTRX_W, default 336, giving the width of one flattened signed matrix.
REQ-003 SHALL have parameter GAP, default 6, giving the idle cycles between consecutive matrix transfers (range 0..15).
REQ-004 SHALL have port CLK, input, 1 bit: system clock, all logic on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port start, input, 1 bit: frame-start request.
REQ-007 SHALL have port abort, input, 1 bit: synchronous frame cancel.
REQ-008 SHALL have port cont, input, 1 bit: continuous mode, sampled in DONE.
REQ-009 SHALL have port mtrx_in, input, N_MTRX*MTRX_W bits: matrix k occupies bits [(k+1)*MTRX_W-1 : k*MTRX_W], k=0..N_MTRX-1.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts the presented matrix.
REQ-011 SHALL have port out_valid, output, 1 bit: out_data/out_idx are valid.
REQ-012 SHALL have port out_data, output, MTRX_W bits, signed: the presented matrix.
REQ-013 SHALL have port out_idx, output, 4 bits: 1-based index of the presented matrix, 0 when none is presented.
REQ-014 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-015 SHALL have port done, output, 1 bit: one-cycle pulse after the last transfer of a frame.
REQ-016 SHALL have port overrun, output, 1 bit: sticky flag for a start received while busy.

Function
REQ-017 SHALL implement the states IDLE, SEND, GAP and DONE.
REQ-018 In IDLE with start=1 at an edge, SHALL capture all of mtrx_in into a snapshot bank, set k=0 and enter SEND; out_valid rises on the next cycle (1-cycle latency).
REQ-019 In SEND, SHALL drive out_valid=1, out_data=snapshot[k], out_idx=k+1, holding these stable until out_valid&out_ready.
REQ-020 On a transfer with k<N_MTRX-1, SHALL increment k and enter GAP if GAP>0, otherwise enter SEND directly (back-to-back transfers).
REQ-021 In GAP, SHALL drive out_valid=0 for exactly GAP cycles, then return to SEND.
REQ-022 On the transfer of matrix k=N_MTRX-1, SHALL enter DONE, asserting done=1 for that single cycle.
REQ-023 In DONE with cont=1, SHALL recapture the snapshot, set k=0 and enter SEND; with cont=0 it SHALL enter IDLE.
REQ-024 Whenever out_valid=0, SHALL drive out_data to all-zero and out_idx to 0.
REQ-025 The snapshot SHALL be immune to changes on mtrx_in during a frame.
REQ-026 abort=1 SHALL force IDLE from any state at the next edge, with no done pulse; abort SHALL take priority over start and transfers in the same cycle.
REQ-027 start=1 outside IDLE SHALL be ignored and SHALL set overrun.
REQ-028 overrun SHALL clear when a start is accepted in IDLE.
REQ-029 Simultaneous start and abort in IDLE SHALL leave the block in IDLE.
REQ-030 The GAP counter and k SHALL be sized by $clog2 of their ranges and SHALL never wrap beyond their terminal values.

Reset
REQ-031 On rst=1, SHALL asynchronously force: state IDLE, k=0, GAP counter=0, out_valid=0, out_data=0, out_idx=0, busy=0, done=0, overrun=0, and snapshot bank all-zero.
REQ-032 A reset asserted mid-frame SHALL discard the frame without a done pulse.

Structure
REQ-033 The state encoding, MTRX_W default and N_MTRX default SHALL live in a shared package mtrx_pkg, alongside the existing matrix-format constants.
REQ-034 The snapshot bank plus its index mux SHALL be a sub-module mtrx_snap_bank (parameters N_MTRX, MTRX_W; ports load, sel, data).
REQ-035 The FSM, counters and flags SHALL remain in mtrx_stream_seq.

Verification
REQ-036 Frame, N_MTRX=6, GAP=6, out_ready tied high: after a start pulse, out_idx SHALL read 1..6, each valid for 1 cycle and separated by 6 idle cycles; done SHALL pulse once, 36 cycles after start.
REQ-037 Backpressure: hold out_ready=0 for 10 cycles on idx 3. out_data SHALL stay equal to snapshot[2], the cycle before release included, and out_idx 3→4 SHALL follow only after release plus GAP.
REQ-038 Snapshot: change mtrx_in to all-ones after start. All six transfers SHALL still carry the pre-start values.
REQ-039 Abort with start: assert abort together with start during idx 4. The block SHALL be in IDLE next cycle with out_valid=0 and no done pulse.
REQ-040 Overrun and cont: a start during idx 2 SHALL set overrun=1, which SHALL clear on the next accepted start. With cont=1, done SHALL be followed by idx 1 with freshly captured data.
REQ-041 Reset and GAP=0: assert rst mid-GAP; all outputs SHALL read 0 immediately. Then, with GAP=0, a start SHALL give six back-to-back valid cycles and done on the 7th cycle.
